// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: memory op encodings,
// bus FSM states, exception codes and the MEM/WB register layout.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'h0,
        MEM_OP_LDW = 2'h1,
        MEM_OP_STW = 2'h2
    } mem_op_e;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'h0,
        BUS_IF_REQ    = 2'h1,
        BUS_IF_ACCESS = 2'h2,
        BUS_IF_STALL  = 2'h3
    } bus_if_state_e;

    localparam logic [2:0] EXP_NO_EXP     = 3'h0;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'h4;

    localparam logic [1:0] CTRL_OP_NOP = 2'h0;

    localparam logic [2:0] SPM_PREFIX_DEFAULT = 3'b011;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br_flag;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_we_n;
        logic [2:0]  exp_code;
        logic [31:0] out;
    } mem_wb_t;

    // Pipeline bubble; also the reset value of the MEM/WB register.
    localparam mem_wb_t MEM_WB_BUBBLE = '{
        pc:       30'h0,
        en:       1'b0,
        br_flag:  1'b0,
        ctrl_op:  CTRL_OP_NOP,
        dst_addr: 5'h0,
        gpr_we_n: 1'b1,
        exp_code: EXP_NO_EXP,
        out:      32'h0
    };

    function automatic logic is_word_aligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// System-bus master for word loads/stores: request/grant handshake,
// single-cycle address strobe, ready wait and a read buffer that keeps the
// loaded word while the pipeline is stalled.
module bus_if
    import mem_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        req_i,
    input  logic        rw_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] wr_data_i,
    output logic        busy_o,
    output logic [31:0] rd_data_o,
    output logic        bus_req_n_o,
    input  logic        bus_grnt_n_i,
    output logic [29:0] bus_addr_o,
    output logic        bus_as_n_o,
    output logic        bus_rw_o,
    output logic [31:0] bus_wr_data_o,
    input  logic [31:0] bus_rd_data_i,
    input  logic        bus_rdy_n_i
);

    bus_if_state_e state_q, state_d;
    logic [31:0]   rd_buf_q, rd_buf_d;

    // State and read buffer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= BUS_IF_IDLE;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Next state and bus drive; everything is gated by reset so the bus is
    // released asynchronously, and by flush so a pending request is dropped.
    always_comb begin
        state_d       = state_q;
        rd_buf_d      = rd_buf_q;
        busy_o        = 1'b0;
        rd_data_o     = '0;
        bus_req_n_o   = 1'b1;
        bus_as_n_o    = 1'b1;
        bus_addr_o    = '0;
        bus_rw_o      = 1'b1;
        bus_wr_data_o = '0;
        if (flush_i) begin
            state_d = BUS_IF_IDLE;
        end else if (rst_n_i) begin
            case (state_q)
                BUS_IF_IDLE: begin
                    if (req_i) begin
                        bus_req_n_o = 1'b0;
                        busy_o      = 1'b1;
                        state_d     = BUS_IF_REQ;
                    end
                end
                BUS_IF_REQ: begin
                    bus_req_n_o = 1'b0;
                    busy_o      = 1'b1;
                    if (!bus_grnt_n_i) begin
                        bus_as_n_o    = 1'b0;
                        bus_addr_o    = addr_i;
                        bus_rw_o      = rw_i;
                        bus_wr_data_o = wr_data_i;
                        state_d       = BUS_IF_ACCESS;
                    end
                end
                BUS_IF_ACCESS: begin
                    bus_req_n_o = 1'b0;
                    busy_o      = 1'b1;
                    if (!bus_rdy_n_i) begin
                        busy_o    = 1'b0;
                        rd_data_o = bus_rd_data_i;
                        rd_buf_d  = bus_rd_data_i;
                        state_d   = stall_i ? BUS_IF_STALL : BUS_IF_IDLE;
                    end
                end
                BUS_IF_STALL: begin
                    rd_data_o = rd_buf_q;
                    if (!stall_i) begin
                        state_d = BUS_IF_IDLE;
                    end
                end
                default: begin
                    state_d = BUS_IF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// CPU memory-access stage: decodes the EX/MEM register into SPM or bus word
// accesses, flags misaligned accesses and holds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [2:0] SPM_PREFIX = SPM_PREFIX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] spm_rd_data,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    output logic [31:0] fwd_data,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    logic        is_load;
    logic        mem_op_active;
    logic        miss_align;
    logic        spm_acc;
    logic        bus_acc;
    logic [31:0] bus_rd_word;
    logic [31:0] stage_result;
    mem_wb_t     mem_wb_q, mem_wb_d;

    // Access decode; reset suppresses every strobe so outputs settle at once.
    always_comb begin
        is_load       = (ex_mem_op == MEM_OP_LDW);
        mem_op_active = reset && ex_en && (ex_exp_code == EXP_NO_EXP) &&
                        (is_load || (ex_mem_op == MEM_OP_STW));
        miss_align    = mem_op_active && !is_word_aligned(ex_out);
        spm_acc       = mem_op_active && !miss_align && (ex_out[31:29] == SPM_PREFIX);
        bus_acc       = mem_op_active && !miss_align && (ex_out[31:29] != SPM_PREFIX);
    end

    // SPM drive: the SPM is clocked on the inverted edge, so read data is
    // usable in the same cycle.
    always_comb begin
        spm_as_     = !spm_acc;
        spm_addr    = ex_out[31:2];
        spm_rw      = is_load;
        spm_wr_data = ex_mem_wr_data;
    end

    bus_if u_bus_if (
        .clk_i         (clk),
        .rst_n_i       (reset),
        .stall_i       (stall),
        .flush_i       (flush),
        .req_i         (bus_acc),
        .rw_i          (is_load),
        .addr_i        (ex_out[31:2]),
        .wr_data_i     (ex_mem_wr_data),
        .busy_o        (busy),
        .rd_data_o     (bus_rd_word),
        .bus_req_n_o   (bus_req_),
        .bus_grnt_n_i  (bus_grnt_),
        .bus_addr_o    (bus_addr),
        .bus_as_n_o    (bus_as_),
        .bus_rw_o      (bus_rw),
        .bus_wr_data_o (bus_wr_data),
        .bus_rd_data_i (bus_rd_data),
        .bus_rdy_n_i   (bus_rdy_)
    );

    // Stage result: loaded word for a performed load, otherwise the ALU value
    // (a misaligned load performs no access and passes ex_out through).
    always_comb begin
        stage_result = ex_out;
        if (is_load && spm_acc) begin
            stage_result = spm_rd_data;
        end else if (is_load && bus_acc) begin
            stage_result = bus_rd_word;
        end
        fwd_data = stage_result;
    end

    // MEM/WB next value: stall holds (even over flush), flush loads a bubble.
    always_comb begin
        mem_wb_d = mem_wb_q;
        if (!stall) begin
            if (flush) begin
                mem_wb_d = MEM_WB_BUBBLE;
            end else begin
                mem_wb_d.pc       = ex_pc;
                mem_wb_d.en       = ex_en;
                mem_wb_d.br_flag  = ex_br_flag;
                mem_wb_d.ctrl_op  = ex_ctrl_op;
                mem_wb_d.dst_addr = ex_dst_addr;
                mem_wb_d.gpr_we_n = ex_gpr_we_;
                mem_wb_d.exp_code = miss_align ? EXP_MISS_ALIGN : ex_exp_code;
                mem_wb_d.out      = stage_result;
            end
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wb_q <= MEM_WB_BUBBLE;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign mem_pc       = mem_wb_q.pc;
    assign mem_en       = mem_wb_q.en;
    assign mem_br_flag  = mem_wb_q.br_flag;
    assign mem_ctrl_op  = mem_wb_q.ctrl_op;
    assign mem_dst_addr = mem_wb_q.dst_addr;
    assign mem_gpr_we_  = mem_wb_q.gpr_we_n;
    assign mem_exp_code = mem_wb_q.exp_code;
    assign mem_out      = mem_wb_q.out;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: SPM stub, scripted bus slave and a
// reference model of the stage's access rules.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int CYC_LIMIT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, stall_x, flush;
    logic        busy;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;
    logic [29:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [31:0] spm_wr_data, spm_rd_data;
    logic        bus_req_, bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_, bus_rw;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic        bus_rdy_;
    logic [31:0] fwd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    int n_checks = 0;
    int n_fail   = 0;

    // observations from run_op
    int          obs_busy;
    bit          obs_req, obs_as, obs_spm, obs_timeout;
    logic [29:0] obs_baddr;
    logic        obs_brw;
    logic [31:0] obs_bwd, obs_fwd;
    // side-band fields driven by run_op
    logic [29:0] drv_pc;
    logic        drv_br;
    logic [1:0]  drv_ctrl;
    logic [4:0]  drv_dst;
    logic        drv_we;

    logic [31:0] spm_stub [0:255];
    logic [31:0] ref_spm [int unsigned];

    always #5 clk = ~clk;

    // control unit: stall the pipeline while the stage is busy
    assign stall = busy | stall_x;

    // SPM stub with combinational read
    assign spm_rd_data = spm_stub[spm_addr[7:0]];
    always @(posedge clk) begin
        if (!spm_as_ && !spm_rw) spm_stub[spm_addr[7:0]] <= spm_wr_data;
    end

    mem_stage #(.SPM_PREFIX(3'b011)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data),
        .spm_rd_data(spm_rd_data), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .fwd_data(fwd_data),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    task automatic ex_bubble();
        ex_en = 1'b0; ex_mem_op = MEM_OP_NOP; ex_exp_code = EXP_NO_EXP;
        ex_out = 32'h0; ex_mem_wr_data = 32'h0;
    endtask

    task automatic set_ex(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] exp, input logic en);
        drv_pc = 30'($urandom); drv_br = 1'($urandom); drv_ctrl = 2'($urandom);
        drv_dst = 5'($urandom); drv_we = 1'($urandom);
        ex_pc = drv_pc; ex_br_flag = drv_br; ex_ctrl_op = drv_ctrl;
        ex_dst_addr = drv_dst; ex_gpr_we_ = drv_we;
        ex_en = en; ex_mem_op = op; ex_mem_wr_data = wdata; ex_exp_code = exp; ex_out = addr;
    endtask

    // Issue one instruction (called just after a posedge) and run it until the
    // MEM/WB register captures it; the bus slave grants after gnt_dly REQ
    // cycles and signals ready after rdy_dly ACCESS cycles.
    task automatic run_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] exp, input logic en, input int gnt_dly,
                          input int rdy_dly, input logic [31:0] rword);
        int req_cnt = 0;
        int acc_cnt = 0;
        bit as_seen = 0;
        bit done = 0;
        obs_busy = 0; obs_req = 0; obs_as = 0; obs_spm = 0; obs_timeout = 0;
        obs_baddr = '0; obs_brw = 1'b0; obs_bwd = '0; obs_fwd = '0;
        set_ex(op, addr, wdata, exp, en);
        for (int cyc = 0; cyc < CYC_LIMIT && !done; cyc++) begin
            bus_grnt_   = !(!as_seen && req_cnt >= gnt_dly + 1);
            bus_rdy_    = !(as_seen && acc_cnt >= rdy_dly);
            bus_rd_data = bus_rdy_ ? $urandom : rword;
            @(negedge clk);
            if (busy) obs_busy++;
            if (!bus_req_) begin obs_req = 1; req_cnt++; end
            if (as_seen) acc_cnt++;
            if (!bus_as_) begin
                as_seen = 1; obs_as = 1;
                obs_baddr = bus_addr; obs_brw = bus_rw; obs_bwd = bus_wr_data;
            end
            if (!spm_as_) obs_spm = 1;
            if (!stall) begin done = 1; obs_fwd = fwd_data; end
            @(posedge clk); #1;
        end
        if (!done) obs_timeout = 1;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        ex_bubble();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_ex(MEM_OP_LDW, 32'h0000_0200, 32'h0, EXP_NO_EXP, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++; if (bus_req_ !== 1'b1) begin n_fail++; $display("FAIL reset bus_req_: got %b need 1", bus_req_); end
        n_checks++; if (bus_as_ !== 1'b1) begin n_fail++; $display("FAIL reset bus_as_: got %b need 1", bus_as_); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b need 0", busy); end
        n_checks++; if (mem_gpr_we_ !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL reset we_/en: got %b/%b need 1/0", mem_gpr_we_, mem_en); end
        n_checks++; if (mem_exp_code !== EXP_NO_EXP || mem_out !== 32'h0 || mem_pc !== 30'h0) begin
            n_fail++; $display("FAIL reset exp/out/pc: got %h/%h/%h need 0/0/0", mem_exp_code, mem_out, mem_pc); end
        ex_bubble();
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_spm_round_trip();
        run_op(MEM_OP_STW, 32'h6000_0010, 32'hDEAD_BEEF, EXP_NO_EXP, 1'b1, 0, 0, 32'h0);
        ref_spm[32'h6000_0010 >> 2] = 32'hDEAD_BEEF;
        n_checks++; if (obs_busy !== 0 || obs_spm !== 1'b1) begin n_fail++; $display("FAIL spm_stw busy/strobe: got %0d/%b need 0/1", obs_busy, obs_spm); end
        run_op(MEM_OP_LDW, 32'h6000_0010, 32'h0, EXP_NO_EXP, 1'b1, 0, 0, 32'h0);
        n_checks++; if (mem_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL spm_ldw mem_out: got %h need deadbeef", mem_out); end
        n_checks++; if (obs_busy !== 0 || obs_req !== 1'b0) begin n_fail++; $display("FAIL spm_ldw busy/req: got %0d/%b need 0/0", obs_busy, obs_req); end
    endtask

    task automatic test_bus_load();
        run_op(MEM_OP_LDW, 32'h0000_0100, 32'h0, EXP_NO_EXP, 1'b1, 1, 1, 32'h1234_5678);
        n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL bus_load timeout: got 1 need 0"); end
        n_checks++; if (obs_busy !== 4) begin n_fail++; $display("FAIL bus_load busy cycles: got %0d need 4", obs_busy); end
        n_checks++; if (mem_out !== 32'h1234_5678) begin n_fail++; $display("FAIL bus_load mem_out: got %h need 12345678", mem_out); end
        n_checks++; if (obs_baddr !== 30'h40 || obs_brw !== 1'b1) begin n_fail++; $display("FAIL bus_load addr/rw: got %h/%b need 40/1", obs_baddr, obs_brw); end
    endtask

    task automatic test_misaligned();
        run_op(MEM_OP_STW, 32'h6000_0002, 32'h5555_AAAA, EXP_NO_EXP, 1'b1, 0, 0, 32'h0);
        n_checks++; if (mem_exp_code !== EXP_MISS_ALIGN) begin n_fail++; $display("FAIL misalign exp: got %h need %h", mem_exp_code, EXP_MISS_ALIGN); end
        n_checks++; if (obs_spm || obs_req || obs_busy != 0) begin n_fail++; $display("FAIL misalign strobes spm/req/busy: got %b/%b/%0d need 0/0/0", obs_spm, obs_req, obs_busy); end
        run_op(MEM_OP_LDW, 32'h0000_0101, 32'h0, 3'h3, 1'b1, 0, 0, 32'h0);
        n_checks++; if (mem_exp_code !== 3'h3) begin n_fail++; $display("FAIL misalign_keep exp: got %h need 3", mem_exp_code); end
    endtask

    task automatic test_stall_after_ready();
        logic [31:0] held;
        held = mem_out;
        set_ex(MEM_OP_LDW, 32'h0000_0400, 32'h0, EXP_NO_EXP, 1'b1);
        @(posedge clk); #1;
        bus_grnt_ = 1'b0;
        @(posedge clk); #1;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_0F0F; stall_x = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy busy: got %b need 0", busy); end
        @(posedge clk); #1;
        bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD_0BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (dut.u_bus_if.state_q !== BUS_IF_STALL) begin n_fail++; $display("FAIL stall_hold[%0d] state: got %0d need %0d", c, dut.u_bus_if.state_q, BUS_IF_STALL); end
            n_checks++; if (fwd_data !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL stall_hold[%0d] fwd_data: got %h need a5a50f0f", c, fwd_data); end
            n_checks++; if (mem_out !== held) begin n_fail++; $display("FAIL stall_hold[%0d] mem_out: got %h need %h", c, mem_out, held); end
            @(posedge clk); #1;
        end
        stall_x = 1'b0;
        @(posedge clk); #1;
        ex_bubble();
        n_checks++; if (mem_out !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL stall_release mem_out: got %h need a5a50f0f", mem_out); end
        n_checks++; if (dut.u_bus_if.state_q !== BUS_IF_IDLE) begin n_fail++; $display("FAIL stall_release state: got %0d need 0", dut.u_bus_if.state_q); end
    endtask

    task automatic test_flush();
        set_ex(MEM_OP_LDW, 32'h0000_0200, 32'h0, EXP_NO_EXP, 1'b1);
        @(negedge clk);
        n_checks++; if (bus_req_ !== 1'b0) begin n_fail++; $display("FAIL flush pre bus_req_: got %b need 0", bus_req_); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_bubble();
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0 || mem_gpr_we_ !== 1'b1) begin n_fail++; $display("FAIL flush en/we_: got %b/%b need 0/1", mem_en, mem_gpr_we_); end
        n_checks++; if (dut.u_bus_if.state_q !== BUS_IF_IDLE) begin n_fail++; $display("FAIL flush state: got %0d need 0", dut.u_bus_if.state_q); end
        n_checks++; if (bus_req_ !== 1'b1) begin n_fail++; $display("FAIL flush bus_req_: got %b need 1", bus_req_); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_flush();
        run_op(MEM_OP_STW, 32'h6000_0020, 32'h1, EXP_NO_EXP, 1'b1, 0, 0, 32'h0);
        ref_spm[32'h6000_0020 >> 2] = 32'h1;
        stall_x = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        stall_x = 1'b0; flush = 1'b0;
        n_checks++; if (mem_en !== 1'b1 || mem_out !== 32'h6000_0020) begin n_fail++; $display("FAIL stall_flush hold en/out: got %b/%h need 1/60000020", mem_en, mem_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [2:0]  exp, pfx, exp_exp;
            logic        en, valid, misal, to_spm, to_bus;
            logic [1:0]  mis;
            logic [31:0] addr, wdata, rword, exp_res;
            int          gnt, rdy, exp_busy;
            op    = 2'($urandom_range(0, 2));
            en    = ($urandom_range(0, 9) != 0);
            exp   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : EXP_NO_EXP;
            mis   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                addr = {3'b011, 21'h0, 6'($urandom), mis};
            end else begin
                do pfx = 3'($urandom); while (pfx == 3'b011);
                addr = {pfx, 27'($urandom), mis};
            end
            wdata = $urandom; rword = $urandom;
            gnt = $urandom_range(0, 3); rdy = $urandom_range(0, 3);
            // reference rules
            valid    = en && (exp == EXP_NO_EXP) && (op != MEM_OP_NOP);
            misal    = valid && (addr[1:0] != 2'b00);
            to_spm   = valid && !misal && (addr[31:29] == 3'b011);
            to_bus   = valid && !misal && (addr[31:29] != 3'b011);
            exp_exp  = misal ? EXP_MISS_ALIGN : exp;
            exp_busy = to_bus ? gnt + rdy + 2 : 0;
            exp_res  = addr;
            if (op == MEM_OP_LDW && to_spm) exp_res = ref_spm.exists(addr >> 2) ? ref_spm[addr >> 2] : 32'h0;
            if (op == MEM_OP_LDW && to_bus) exp_res = rword;
            run_op(op, addr, wdata, exp, en, gnt, rdy, rword);
            if (op == MEM_OP_STW && to_spm) ref_spm[addr >> 2] = wdata;
            n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL rnd[%0d] timeout: got 1 need 0", i); end
            n_checks++; if (mem_out !== exp_res || obs_fwd !== exp_res) begin n_fail++; $display("FAIL rnd[%0d] mem_out/fwd: got %h/%h need %h", i, mem_out, obs_fwd, exp_res); end
            n_checks++; if (mem_exp_code !== exp_exp) begin n_fail++; $display("FAIL rnd[%0d] exp: got %h need %h", i, mem_exp_code, exp_exp); end
            n_checks++; if (mem_en !== en || mem_pc !== drv_pc || mem_br_flag !== drv_br) begin n_fail++; $display("FAIL rnd[%0d] en/pc/br: got %b/%h/%b need %b/%h/%b", i, mem_en, mem_pc, mem_br_flag, en, drv_pc, drv_br); end
            n_checks++; if (mem_ctrl_op !== drv_ctrl || mem_dst_addr !== drv_dst || mem_gpr_we_ !== drv_we) begin n_fail++; $display("FAIL rnd[%0d] ctrl/dst/we_: got %h/%h/%b need %h/%h/%b", i, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, drv_ctrl, drv_dst, drv_we); end
            n_checks++; if (obs_busy != exp_busy) begin n_fail++; $display("FAIL rnd[%0d] busy cycles: got %0d need %0d", i, obs_busy, exp_busy); end
            n_checks++; if (obs_spm != to_spm || obs_req != to_bus || obs_as != to_bus) begin n_fail++; $display("FAIL rnd[%0d] spm/req/as: got %b/%b/%b need %b/%b/%b", i, obs_spm, obs_req, obs_as, to_spm, to_bus, to_bus); end
            if (to_bus) begin
                n_checks++;
                if (obs_baddr !== addr[31:2] || obs_brw !== (op == MEM_OP_LDW) || (op == MEM_OP_STW && obs_bwd !== wdata)) begin
                    n_fail++; $display("FAIL rnd[%0d] bus addr/rw/wd: got %h/%b/%h need %h/%b/%h", i, obs_baddr, obs_brw, obs_bwd, addr[31:2], op == MEM_OP_LDW, wdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        run_op(MEM_OP_STW, 32'h6000_0030, 32'h77, EXP_NO_EXP, 1'b1, 0, 0, 32'h0);
        ref_spm[32'h6000_0030 >> 2] = 32'h77;
        set_ex(MEM_OP_LDW, 32'h0000_0800, 32'h0, EXP_NO_EXP, 1'b1);
        @(posedge clk); #1;
        bus_grnt_ = 1'b0;
        @(posedge clk); #1;
        bus_grnt_ = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || bus_req_ !== 1'b0) begin n_fail++; $display("FAIL rst_mid pre busy/req_: got %b/%b need 1/0", busy, bus_req_); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid bus req_/as_/busy: got %b/%b/%b need 1/1/0", bus_req_, bus_as_, busy); end
        n_checks++; if (mem_en !== 1'b0 || mem_gpr_we_ !== 1'b1 || mem_out !== 32'h0 || mem_pc !== 30'h0 || mem_exp_code !== EXP_NO_EXP) begin
            n_fail++; $display("FAIL rst_mid mem en/we_/out/pc/exp: got %b/%b/%h/%h/%h need 0/1/0/0/0", mem_en, mem_gpr_we_, mem_out, mem_pc, mem_exp_code); end
        n_checks++; if (dut.u_bus_if.state_q !== BUS_IF_IDLE) begin n_fail++; $display("FAIL rst_mid state: got %0d need 0", dut.u_bus_if.state_q); end
        ex_bubble();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) spm_stub[i] = 32'h0;
        stall_x = 1'b0; flush = 1'b0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
        ex_pc = '0; ex_br_flag = 1'b0; ex_ctrl_op = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1;
        ex_bubble();
        test_reset();
        test_spm_round_trip();
        test_bus_load();
        test_misaligned();
        test_stall_after_ready();
        test_flush();
        test_stall_flush();
        test_random();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
